solenoid_driver: RTL and testbench
==================================

# solenoid_driver

Downstream power stage for the solenoid firing path. It consumes the level `trigger_in` produced by `trigger_solenoid` and drives the solenoid MOSFET gate. The gate profile is a full-on pull-in phase followed by a PWM hold phase, and the block enforces a maximum on-time and a post-fire cooldown. All profile parameters are configurable over its own APB3 slave on the same bus.

## Interface
Parameters:
- DEF_PULLIN, 16'd5000, reset value of the pull-in length in PCLK cycles.
- DEF_PWM_PERIOD, 16'd100, reset value of the hold PWM period in cycles.
- DEF_HOLD_DUTY, 16'd30, reset value of the hold PWM high cycles per period.
- DEF_MAXON, 32'd1_000_000, reset value of the max on-time in cycles (0 = unlimited).
- DEF_COOLDOWN, 24'd10000, reset value of the cooldown length in cycles.

Ports:
- PCLK  in  1  single clock. Everything is synchronous to PCLK.
- PRESERN  in  1  reset, synchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB write.
- PADDR  in  32  address. Only [7:0] is decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied to 1.
- PSLVERR  out  1  tied to 0.
- trigger_in  in  1  fire request level from `trigger_solenoid`, same clock domain.
- solenoid_gate  out  1  registered MOSFET gate drive.
- busy  out  1  high in PULLIN, HOLD and COOLDOWN.
- fault  out  1  sticky max-on timeout flag.

## Operation
Register map, decoded on PADDR[7:0]:
- A write takes effect when PSEL & PWRITE & PENABLE.
- Reads are a combinational mux on PADDR[7:0]. Unmapped addresses read 0.
- 0x00 CTRL:
  - bit0 enable (reset 0).
  - bit1 fault_clr: write-1 clears fault. It does not store and reads 0.
- 0x04 PULLIN [15:0].
- 0x08 PWM: [15:0] period, [31:16] duty.
- 0x0C MAXON [31:0].
- 0x10 COOLDOWN [23:0].
- 0x14 STATUS (RO): [1:0] state, bit2 fault, bit3 solenoid_gate, bit4 armed.

State machine:
- State encodings: IDLE=0, PULLIN=1, HOLD=2, COOLDOWN=3.
- IDLE:
  - gate 0.
  - Moves to PULLIN when trigger_in & enable & armed & ~fault.
  - Entering PULLIN loads the phase counter with PULLIN and clears the on-time counter.
- PULLIN:
  - gate 1.
  - Moves to HOLD when the phase counter reaches 0. With PULLIN=0, PULLIN lasts exactly 1 cycle.
- HOLD:
  - gate = (pwm_cnt < duty).
  - pwm_cnt runs 0..period-1 and wraps, restarting at 0 on HOLD entry.
  - period=0 or duty>=period gives gate held at 1. duty=0 gives gate held at 0.
- COOLDOWN:
  - gate 0.
  - Loads the phase counter with COOLDOWN on entry and returns to IDLE when it reaches 0.
  - trigger_in is ignored.
- Exits from PULLIN/HOLD to COOLDOWN, in priority order:
  1. enable=0.
  2. The on-time counter reaches MAXON (MAXON≠0). This also sets fault.
  3. trigger_in=0.
- Arming:
  - armed clears on PULLIN entry and sets whenever trigger_in=0.
  - A trigger held high through a timeout or cooldown therefore never re-fires. A new rising level is required.
- Live configuration:
  - PWM period/duty are used live, and a change applies at the next comparison.
  - PULLIN and COOLDOWN are sampled only at phase entry.
  - MAXON is compared live.
- When a fault set and a fault_clr write land in the same cycle, the set wins.

## Timing
- Reset values: solenoid_gate 0, busy 0, fault 0, armed 1, state IDLE, enable 0. Configuration registers take their DEF_* values.
- Latency: trigger_in high at edge n gives state PULLIN and solenoid_gate=1 after edge n+1. trigger_in low gives gate 0 one cycle later.
- PULLIN lasts PULLIN+1 cycles when PULLIN>0, or 1 cycle when PULLIN=0. COOLDOWN lasts COOLDOWN+1 cycles.
- On-time counts every cycle spent in PULLIN or HOLD. The timeout exit happens on the cycle the count equals MAXON, so gate is high for exactly MAXON cycles.
- Reset asserted mid-operation forces IDLE, gate 0 and fault 0 at the next edge. It bypasses cooldown.
- APB has zero wait states. A write is visible on reads in the next cycle.

## Structure
- Package `solenoid_pkg` holds:
  - the state enum;
  - the register offset constants (CTRL, PULLIN, PWM, MAXON, COOLDOWN, STATUS);
  - the STATUS bit positions.
- Sub-module `solenoid_pwm` contains:
  - inputs: clk, rst_n, run, period, duty;
  - output: pwm;
  - the wrap counter and the degenerate period/duty rules.
- The top level holds the APB register file, the FSM, the phase counter and the on-time counter.

## Test plan
- Nominal fire: config PULLIN=4, period=10, duty=3, enable=1; trigger_in high 40 cycles.
  - Gate is high 5 cycles, then a 3-high/7-low pattern.
  - Gate is low 1 cycle after trigger drops, busy stays high for COOLDOWN+1 cycles, then IDLE.
- Timeout: MAXON=20, trigger_in held 100 cycles.
  - Gate is high for 20 cycles, then fault=1 and COOLDOWN.
  - No re-fire until trigger_in goes low and fault is cleared via CTRL=0x3.
- Cooldown lockout: trigger pulses of 5 cycles during COOLDOWN=50 cause no gate activity. A trigger after return to IDLE fires normally.
- Degenerate PWM: period=0, then duty=12 with period=10, then duty=0. Required responses are hold gate constant 1, constant 1 and constant 0 respectively.
- Disable mid-HOLD: write CTRL=0 during HOLD. Gate goes 0 on the next cycle and the FSM enters COOLDOWN. fault stays 0.
- Reset mid-PULLIN: PRESERN low for 1 cycle. Gate is 0, STATUS reads 0x10, and all config registers read their DEF_* values.

Source files
------------

// File: rtl/solenoid_pkg.sv
// Shared definitions for the solenoid gate driver: FSM states, register offsets, STATUS bits.
// No logic of its own.
// No flow control.
package solenoid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULLIN   = 2'd1,
    ST_HOLD     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_PULLIN   = 8'h04;
  localparam logic [7:0] REG_PWM      = 8'h08;
  localparam logic [7:0] REG_MAXON    = 8'h0C;
  localparam logic [7:0] REG_COOLDOWN = 8'h10;
  localparam logic [7:0] REG_STATUS   = 8'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FCLR  = 1;

  localparam int STAT_FAULT = 2;
  localparam int STAT_GATE  = 3;
  localparam int STAT_ARMED = 4;

endpackage

// File: rtl/solenoid_pwm.sv
// Hold-phase PWM: free-running wrap counter compared against duty, with degenerate period/duty rules.
// pwm is combinational from the counter; the counter restarts at 0 whenever run drops.
// No flow control; period/duty are used live.
module solenoid_pwm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] period,
  input  logic [15:0] duty,
  output logic        pwm
);

  logic [15:0] cnt;

  // Wrap counter 0..period-1; a shrunk period wraps on the next step instead of running away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (!run) begin
      cnt <= 16'd0;
    end else if ((period == 16'd0) || (cnt >= (period - 16'd1))) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // duty=0 forces off (this also wins for period=0, duty=0); period=0 or duty>=period forces on.
  always_comb begin
    pwm = 1'b0;
    if (!run) begin
      pwm = 1'b0;
    end else if (duty == 16'd0) begin
      pwm = 1'b0;
    end else if ((period == 16'd0) || (duty >= period)) begin
      pwm = 1'b1;
    end else begin
      pwm = (cnt < duty);
    end
  end

endmodule

// File: rtl/solenoid_driver.sv
// Solenoid MOSFET gate driver: pull-in, PWM hold, max-on timeout and cooldown, configured over APB3.
// Gate is registered: trigger seen at an edge drives the gate from that same edge; APB is zero-wait.
// No backpressure: PREADY is always 1, PSLVERR always 0.
module solenoid_driver
  import solenoid_pkg::*;
#(
  parameter logic [15:0] DEF_PULLIN     = 16'd5000,
  parameter logic [15:0] DEF_PWM_PERIOD = 16'd100,
  parameter logic [15:0] DEF_HOLD_DUTY  = 16'd30,
  parameter logic [31:0] DEF_MAXON      = 32'd1_000_000,
  parameter logic [23:0] DEF_COOLDOWN   = 24'd10000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        trigger_in,
  output logic        solenoid_gate,
  output logic        busy,
  output logic        fault
);

  logic        enable;
  logic        armed;
  logic [15:0] pullin_len;
  logic [15:0] pwm_period;
  logic [15:0] pwm_duty;
  logic [31:0] maxon;
  logic [23:0] cooldown_len;

  state_t      state;
  state_t      next_state;
  logic [23:0] phase_cnt;
  logic [31:0] on_cnt;

  logic        fire;
  logic        enter_cool;
  logic        timeout;
  logic        pwm_out;
  logic        wr_en;
  logic        fault_clr;
  logic [7:0]  addr;
  logic        unused_addr;

  assign addr        = PADDR[7:0];
  assign wr_en       = PSEL & PWRITE & PENABLE;
  assign fault_clr   = wr_en && (addr == REG_CTRL) && PWDATA[CTRL_FCLR];
  assign unused_addr = ^PADDR[31:8];

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign busy    = (state != ST_IDLE);

  // Configuration registers; fault_clr is a strobe and is not stored.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      enable       <= 1'b0;
      pullin_len   <= DEF_PULLIN;
      pwm_period   <= DEF_PWM_PERIOD;
      pwm_duty     <= DEF_HOLD_DUTY;
      maxon        <= DEF_MAXON;
      cooldown_len <= DEF_COOLDOWN;
    end else if (wr_en) begin
      case (addr)
        REG_CTRL:     enable       <= PWDATA[CTRL_EN];
        REG_PULLIN:   pullin_len   <= PWDATA[15:0];
        REG_PWM: begin
          pwm_period <= PWDATA[15:0];
          pwm_duty   <= PWDATA[31:16];
        end
        REG_MAXON:    maxon        <= PWDATA;
        REG_COOLDOWN: cooldown_len <= PWDATA[23:0];
        default: ;
      endcase
    end
  end

  // Combinational read mux; unmapped offsets read 0.
  always_comb begin
    PRDATA = 32'd0;
    case (addr)
      REG_CTRL:     PRDATA = {31'd0, enable};
      REG_PULLIN:   PRDATA = {16'd0, pullin_len};
      REG_PWM:      PRDATA = {pwm_duty, pwm_period};
      REG_MAXON:    PRDATA = maxon;
      REG_COOLDOWN: PRDATA = {8'd0, cooldown_len};
      REG_STATUS:   PRDATA = {27'd0, armed, solenoid_gate, fault, state};
      default:      PRDATA = 32'd0;
    endcase
  end

  // Next-state logic; exit priority from the on phases is disable, then timeout, then trigger release.
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger_in && enable && armed && !fault) next_state = ST_PULLIN;
      end
      ST_PULLIN, ST_HOLD: begin
        if (!enable) begin
          next_state = ST_COOLDOWN;
        end else if ((maxon != 32'd0) && (on_cnt == maxon)) begin
          next_state = ST_COOLDOWN;
          timeout    = 1'b1;
        end else if (!trigger_in) begin
          next_state = ST_COOLDOWN;
        end else if ((state == ST_PULLIN) && (phase_cnt == 24'd0)) begin
          next_state = ST_HOLD;
        end
      end
      ST_COOLDOWN: begin
        if (phase_cnt == 24'd0) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign fire       = (state == ST_IDLE) && (next_state == ST_PULLIN);
  assign enter_cool = (state != ST_COOLDOWN) && (next_state == ST_COOLDOWN);

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Phase counter: loaded on PULLIN/COOLDOWN entry, counts down to 0 inside those phases.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      phase_cnt <= 24'd0;
    end else if (fire) begin
      phase_cnt <= {8'd0, pullin_len};
    end else if (enter_cool) begin
      phase_cnt <= cooldown_len;
    end else if (((state == ST_PULLIN) || (state == ST_COOLDOWN)) && (phase_cnt != 24'd0)) begin
      phase_cnt <= phase_cnt - 24'd1;
    end
  end

  // On-time counter: the entry cycle counts as 1 so on_cnt==MAXON lands on the MAXON-th gate cycle.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      on_cnt <= 32'd0;
    end else if (fire) begin
      on_cnt <= 32'd1;
    end else if (((state == ST_PULLIN) || (state == ST_HOLD)) && (on_cnt != 32'hFFFF_FFFF)) begin
      on_cnt <= on_cnt + 32'd1;
    end
  end

  // Arming: a fire consumes it, any low trigger level restores it.
  always_ff @(posedge PCLK) begin
    if (!PRESERN)        armed <= 1'b1;
    else if (!trigger_in) armed <= 1'b1;
    else if (fire)        armed <= 1'b0;
  end

  // Sticky timeout flag; a set in the same cycle as a clear wins.
  always_ff @(posedge PCLK) begin
    if (!PRESERN)       fault <= 1'b0;
    else if (timeout)   fault <= 1'b1;
    else if (fault_clr) fault <= 1'b0;
  end

  solenoid_pwm u_pwm (
    .clk    (PCLK),
    .rst_n  (PRESERN),
    .run    (next_state == ST_HOLD),
    .period (pwm_period),
    .duty   (pwm_duty),
    .pwm    (pwm_out)
  );

  // Registered gate, computed from the state being entered.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) solenoid_gate <= 1'b0;
    else          solenoid_gate <= (next_state == ST_PULLIN) | pwm_out;
  end

endmodule

// File: tb/tb_solenoid_driver.sv
// Self-checking bench for solenoid_driver: register table plus fire/timeout/cooldown/PWM/disable/reset sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every bounded wait that expires shows up as a failed comparison.
module tb_solenoid_driver;

  logic        PCLK = 1'b0;
  logic        PRESERN;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        trigger_in;
  logic        solenoid_gate, busy, fault;

  int checks   = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  solenoid_driver dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .trigger_in(trigger_in), .solenoid_gate(solenoid_gate), .busy(busy), .fault(fault)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {24'd0, a}; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {24'd0, a};
    #1;
    d = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    logic [31:0] s;
    apb_read(8'h14, s);
    check(name, s[1:0], exp);
  endtask

  task automatic cfg(input logic [15:0] pl, input logic [15:0] per, input logic [15:0] dty,
                     input logic [31:0] mx, input logic [23:0] cd);
    apb_write(8'h04, {16'd0, pl});
    apb_write(8'h08, {dty, per});
    apb_write(8'h0C, mx);
    apb_write(8'h10, {8'd0, cd});
    apb_write(8'h00, 32'h1);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [31:0] d;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].wdata);
      apb_read(vecs[i].addr, d);
      check(vecs[i].name, d, vecs[i].exp);
    end
  endtask

  // Counts falling-edge samples with busy high, bounded.
  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (busy && (n < bound)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] gact, gexp;
    logic [31:0] st;
    int n, hi_cnt, seen;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,         32'h0000_0000, "def_ctrl"};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,         32'h0000_1388, "def_pullin"};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,         32'h001E_0064, "def_pwm"};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,         32'h000F_4240, "def_maxon"};
    vecs[4]  = '{1'b0, 8'h10, 32'h0,         32'h0000_2710, "def_cooldown"};
    vecs[5]  = '{1'b0, 8'h14, 32'h0,         32'h0000_0010, "def_status"};
    vecs[6]  = '{1'b0, 8'h18, 32'h0,         32'h0000_0000, "def_unmapped"};
    vecs[7]  = '{1'b1, 8'h04, 32'hABCD_1234, 32'h0000_1234, "wr_pullin"};
    vecs[8]  = '{1'b1, 8'h08, 32'h1234_5678, 32'h1234_5678, "wr_pwm"};
    vecs[9]  = '{1'b1, 8'h0C, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "wr_maxon"};
    vecs[10] = '{1'b1, 8'h10, 32'hFFFF_FFFF, 32'h00FF_FFFF, "wr_cooldown"};
    vecs[11] = '{1'b1, 8'h00, 32'h0000_0003, 32'h0000_0001, "wr_ctrl_en"};
    vecs[12] = '{1'b1, 8'h00, 32'h0000_0000, 32'h0000_0000, "wr_ctrl_off"};
    vecs[13] = '{1'b1, 8'h18, 32'hFFFF_FFFF, 32'h0000_0000, "wr_unmapped"};
    vecs[14] = '{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0000_0010, "wr_status_ro"};

    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'd0; PWDATA = 32'd0; trigger_in = 1'b0;
    tick(); tick();
    PRESERN = 1'b1;
    tick();
    check("rst_gate",  solenoid_gate, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("pready",    PREADY, 1'b1);
    check("pslverr",   PSLVERR, 1'b0);
    run_vecs(0, 14);

    // Nominal fire: 5 pull-in cycles then 3-high/7-low hold pattern.
    cfg(16'd4, 16'd10, 16'd3, 32'd0, 24'd6);
    gact = '0; gexp = '0;
    trigger_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      gact[k-1] = solenoid_gate;
      gexp[k-1] = (k <= 5) ? 1'b1 : (((k - 6) % 10) < 3);
      if (k == 1) check_state("fire_latency", 2'd1);
      if (k == 6) check_state("hold_entry", 2'd2);
    end
    check("nominal_gate", gact, gexp);
    trigger_in = 1'b0;
    tick();
    check("drop_gate", solenoid_gate, 1'b0);
    check_state("drop_cool", 2'd3);
    wait_idle(200, n);
    check("nominal_cool_len", n, 7);
    check_state("nominal_idle", 2'd0);

    // Timeout: gate held on by period=0, MAXON=20.
    cfg(16'd4, 16'd0, 16'd3, 32'd20, 24'd6);
    trigger_in = 1'b1;
    hi_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      hi_cnt += solenoid_gate;
      if (k == 20) check("to_last_on", solenoid_gate, 1'b1);
      if (k == 21) begin
        check("to_fault", fault, 1'b1);
        check_state("to_cool", 2'd3);
      end
    end
    check("to_high_cycles", hi_cnt, 20);
    apb_read(8'h14, st);
    check("to_status_held", st[4:0], 5'b00100);
    trigger_in = 1'b0;
    tick();
    trigger_in = 1'b1;
    tick(); tick(); tick();
    check("fault_blocks_gate", solenoid_gate, 1'b0);
    check_state("fault_blocks_state", 2'd0);
    trigger_in = 1'b0;
    tick();
    apb_write(8'h00, 32'h3);
    check("fault_cleared", fault, 1'b0);
    trigger_in = 1'b1;
    tick();
    check_state("refire", 2'd1);
    trigger_in = 1'b0;
    tick();
    wait_idle(200, n);

    // Cooldown lockout: 5-cycle pulses during a 51-cycle cooldown.
    cfg(16'd4, 16'd10, 16'd3, 32'd0, 24'd50);
    trigger_in = 1'b1;
    tick(); tick(); tick();
    trigger_in = 1'b0;
    tick();
    seen = 0;
    for (int p = 0; p < 4; p++) begin
      trigger_in = 1'b1;
      for (int c = 0; c < 5; c++) begin tick(); seen += solenoid_gate; end
      trigger_in = 1'b0;
      for (int c = 0; c < 5; c++) begin tick(); seen += solenoid_gate; end
    end
    check("lock_no_gate", seen, 0);
    check_state("lock_still_cool", 2'd3);
    wait_idle(200, n);
    check("lock_cool_rest", n, 11);
    trigger_in = 1'b1;
    tick();
    check_state("lock_refire_state", 2'd1);
    check("lock_refire_gate", solenoid_gate, 1'b1);
    trigger_in = 1'b0;
    tick();
    wait_idle(200, n);

    // Degenerate PWM settings, changed live during HOLD.
    cfg(16'd2, 16'd0, 16'd3, 32'd0, 24'd6);
    trigger_in = 1'b1;
    tick(); tick(); tick(); tick();
    check_state("deg_in_hold", 2'd2);
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); hi_cnt += solenoid_gate; end
    check("deg_period0", hi_cnt, 20);
    apb_write(8'h08, 32'h000C_000A);
    tick();
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); hi_cnt += solenoid_gate; end
    check("deg_duty_ge_period", hi_cnt, 20);
    apb_write(8'h08, 32'h0000_000A);
    tick();
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); hi_cnt += solenoid_gate; end
    check("deg_duty0", hi_cnt, 0);

    // Disable mid-HOLD.
    apb_write(8'h08, 32'h0005_0000);
    tick();
    check("dis_gate_on", solenoid_gate, 1'b1);
    apb_write(8'h00, 32'h0);
    check("dis_gate_before", solenoid_gate, 1'b1);
    tick();
    check("dis_gate_off", solenoid_gate, 1'b0);
    check_state("dis_cool", 2'd3);
    check("dis_no_fault", fault, 1'b0);
    trigger_in = 1'b0;
    wait_idle(200, n);

    // Reset mid-PULLIN restores defaults.
    cfg(16'd100, 16'd10, 16'd3, 32'd0, 24'd6);
    trigger_in = 1'b1;
    tick(); tick();
    check_state("rp_pullin", 2'd1);
    PRESERN = 1'b0;
    trigger_in = 1'b0;
    tick();
    check("rp_gate", solenoid_gate, 1'b0);
    check("rp_busy", busy, 1'b0);
    PRESERN = 1'b1;
    run_vecs(0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
